// File: rtl/load_store_issue_unit_pkg.sv
// Shared definitions for the load/store issue unit: FSM states, fault codes
// and access-size encodings.
package lsu_defs;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    FAULT
  } lsu_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_WRAP    = 2'b01,
    FAULT_LDST    = 2'b10,
    FAULT_TIMEOUT = 2'b11
  } fault_code_t;

  localparam logic [1:0] WORD     = 2'b10;
  localparam logic [1:0] HALFWORD = 2'b01;
  localparam logic [1:0] BYTE     = 2'b00;

endpackage

// File: rtl/load_store_issue_unit_if.sv
// Request/response bus between the load/store issue unit (master) and
// memory_interface (slave).
interface load_store_issue_unit_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mi_address;
  logic [DATA_WIDTH-1:0] mi_data_in;
  logic                  mi_load;
  logic                  mi_store;
  logic                  mi_is_signed;
  logic [1:0]            mi_word_type;
  logic [DATA_WIDTH-1:0] mi_data_out;
  logic                  mi_output_valid;
  logic                  mi_write_ready;

  modport master (
    output mi_address, mi_data_in, mi_load, mi_store, mi_is_signed, mi_word_type,
    input  mi_data_out, mi_output_valid, mi_write_ready
  );

  modport slave (
    input  mi_address, mi_data_in, mi_load, mi_store, mi_is_signed, mi_word_type,
    output mi_data_out, mi_output_valid, mi_write_ready
  );
endinterface

// File: rtl/load_store_issue_unit_timeout_counter.sv
// WAIT-cycle counter; expired flags the last permitted WAIT cycle.
module lsu_timeout_counter #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign expired = (count == LAST);
endmodule

// File: rtl/load_store_issue_unit.sv
// Issues one load/store at a time to memory_interface, stalls execute while
// in flight, returns load data to writeback and reports faults.
module load_store_issue_unit
  import lsu_defs::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int TIMEOUT        = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ex_valid,
  input  logic                      ex_load,
  input  logic                      ex_store,
  input  logic                      ex_is_signed,
  input  logic [1:0]                ex_word_type,
  input  logic [ADDR_WIDTH-1:0]     ex_base_addr,
  input  logic [ADDR_WIDTH-1:0]     ex_offset,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic [REG_ADDR_WIDTH-1:0] ex_dest_reg,
  output logic                      stall,
  load_store_issue_unit_if.master   mi,
  output logic                      wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      fault,
  output logic [1:0]                fault_code
);
  lsu_state_t                state;
  logic                      req_load;
  logic [REG_ADDR_WIDTH-1:0] req_dest;
  logic                      expired;

  logic [ADDR_WIDTH-1:0] eff_addr;
  logic                  accept, ldst_err, wrap_err;

  assign eff_addr = ex_base_addr + ex_offset;
  assign accept   = ex_valid && (ex_load || ex_store) && !stall &&
                    (state == IDLE || state == DONE);
  assign ldst_err = ex_load && ex_store;
  // A word spans two halfword lines, so the top line has no successor.
  assign wrap_err = (ex_word_type == WORD) && (&eff_addr);

  lsu_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == ISSUE),
    .enable  (state == WAIT),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      stall           <= 1'b0;
      req_load        <= 1'b0;
      req_dest        <= '0;
      mi.mi_address   <= '0;
      mi.mi_data_in   <= '0;
      mi.mi_load      <= 1'b0;
      mi.mi_store     <= 1'b0;
      mi.mi_is_signed <= 1'b0;
      mi.mi_word_type <= '0;
      wb_valid        <= 1'b0;
      wb_reg          <= '0;
      wb_data         <= '0;
      fault           <= 1'b0;
      fault_code      <= FAULT_NONE;
    end else begin
      mi.mi_load  <= 1'b0;
      mi.mi_store <= 1'b0;
      wb_valid    <= 1'b0;
      fault       <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          stall <= 1'b0;
          if (accept) begin
            stall <= 1'b1;
            if (ldst_err || wrap_err) begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_code <= ldst_err ? FAULT_LDST : FAULT_WRAP;
            end else begin
              state           <= ISSUE;
              mi.mi_load      <= ex_load;
              mi.mi_store     <= ex_store;
              mi.mi_address   <= eff_addr;
              mi.mi_data_in   <= ex_store_data;
              mi.mi_is_signed <= ex_is_signed;
              mi.mi_word_type <= ex_word_type;
              req_load        <= ex_load;
              req_dest        <= ex_dest_reg;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          // A response in the expiring cycle still completes the request.
          if ((req_load && mi.mi_output_valid) || (!req_load && mi.mi_write_ready)) begin
            state    <= DONE;
            stall    <= 1'b0;
            wb_valid <= req_load;
            if (req_load) begin
              wb_reg  <= req_dest;
              wb_data <= mi.mi_data_out;
            end
          end else if (expired) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= FAULT_TIMEOUT;
          end
          if ((req_load && mi.mi_output_valid) || (!req_load && mi.mi_write_ready) || expired) begin
            mi.mi_address   <= '0;
            mi.mi_data_in   <= '0;
            mi.mi_is_signed <= 1'b0;
            mi.mi_word_type <= '0;
          end
        end
        default: begin
          state <= IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_issue_unit.sv
// Self-checking bench: table of request vectors plus hand-written
// back-to-back and mid-request reset sequences, with a writeback scoreboard.
module tb_load_store_issue_unit;
  logic        clk, reset;
  logic        ex_valid, ex_load, ex_store, ex_is_signed;
  logic [1:0]  ex_word_type;
  logic [11:0] ex_base_addr, ex_offset;
  logic [31:0] ex_store_data;
  logic [3:0]  ex_dest_reg;
  logic        stall, wb_valid, fault;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic [1:0]  fault_code;

  load_store_issue_unit_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) mi_bus ();

  load_store_issue_unit #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_is_signed(ex_is_signed), .ex_word_type(ex_word_type),
    .ex_base_addr(ex_base_addr), .ex_offset(ex_offset),
    .ex_store_data(ex_store_data), .ex_dest_reg(ex_dest_reg),
    .stall(stall), .mi(mi_bus),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .fault(fault), .fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] base, off;
    logic        ld, st, sgn;
    logic [1:0]  wt;
    logic [31:0] sdata;
    logic [3:0]  dest;
    int          resp_at;   // WAIT cycle index of the response, -1 for none
    logic        wrong;     // wrong-kind response in WAIT cycle 0
    logic [31:0] rdata;
    logic [11:0] exp_addr;
    logic        exp_ld, exp_st;
    logic [1:0]  exp_code;
    int          exp_stall;
    logic        exp_wb;
  } vec_t;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] d;
  } wb_t;

  wb_t  sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [1:0] last_code = 2'b00;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wb_unexpected: got wb_valid=1 reg=%0d, expected no writeback", wb_reg);
      end else begin
        wb_t e;
        e = sb.pop_front();
        check("wb_reg", {28'h0, wb_reg}, {28'h0, e.r});
        check("wb_data", wb_data, e.d);
      end
    end
  end

  task automatic clear_resp();
    mi_bus.mi_output_valid = 1'b0;
    mi_bus.mi_write_ready  = 1'b0;
    mi_bus.mi_data_out     = 32'h0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   stall_cyc = 0, ld_p = 0, st_p = 0, fault_cyc = 0;
    logic [1:0] code_seen = 2'b00;
    bit   done = 0;
    @(negedge clk);
    ex_valid = 1'b1; ex_load = v.ld; ex_store = v.st; ex_is_signed = v.sgn;
    ex_word_type = v.wt; ex_base_addr = v.base; ex_offset = v.off;
    ex_store_data = v.sdata; ex_dest_reg = v.dest;
    if (v.exp_wb) sb.push_back('{r: v.dest, d: v.rdata});
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      clear_resp();
      if (n == 0) begin
        ex_valid = 1'b0;
        check($sformatf("v%0d_addr", idx), {20'h0, mi_bus.mi_address}, {20'h0, v.exp_addr});
        if (v.exp_code == 2'b00) begin
          check($sformatf("v%0d_data_in", idx), mi_bus.mi_data_in, v.sdata);
          check($sformatf("v%0d_wt_sgn", idx), {29'h0, mi_bus.mi_word_type, mi_bus.mi_is_signed},
                {29'h0, v.wt, v.sgn});
        end
      end
      if (!stall) begin
        done = 1;
        break;
      end
      stall_cyc++;
      ld_p += int'(mi_bus.mi_load);
      st_p += int'(mi_bus.mi_store);
      if (fault) begin
        fault_cyc++;
        code_seen = fault_code;
      end
      if (n >= 1 && n - 1 == v.resp_at) begin
        mi_bus.mi_data_out     = v.rdata;
        mi_bus.mi_output_valid = v.ld;
        mi_bus.mi_write_ready  = v.st;
      end else if (v.wrong && n == 1) begin
        mi_bus.mi_data_out     = 32'hBAD0BAD0;
        mi_bus.mi_output_valid = v.st;
        mi_bus.mi_write_ready  = v.ld;
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL v%0d_stall_bound: stall still high after 40 cycles, expected release", idx);
    end
    if (v.exp_code != 2'b00) last_code = v.exp_code;
    check($sformatf("v%0d_stall_cycles", idx), stall_cyc, v.exp_stall);
    check($sformatf("v%0d_ld_pulses", idx), ld_p, {31'h0, v.exp_ld});
    check($sformatf("v%0d_st_pulses", idx), st_p, {31'h0, v.exp_st});
    check($sformatf("v%0d_fault_cycles", idx), fault_cyc, (v.exp_code != 2'b00) ? 1 : 0);
    check($sformatf("v%0d_fault_code_pulse", idx), {30'h0, code_seen}, {30'h0, v.exp_code});
    check($sformatf("v%0d_wb_valid", idx), {31'h0, wb_valid}, {31'h0, v.exp_wb});
    check($sformatf("v%0d_fault_code_held", idx), {30'h0, fault_code}, {30'h0, last_code});
    @(negedge clk);
    check($sformatf("v%0d_idle_addr", idx), {20'h0, mi_bus.mi_address}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    //          base    off     ld    st    sgn   wt     sdata         dest  rsp wr    rdata          addr    eld   est   code   stl wb
    tbl[0]  = '{12'h100, 12'h004, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0,        4'd5,  1, 1'b0, 32'hDEADBEEF, 12'h104, 1'b1, 1'b0, 2'b00, 3, 1'b1};
    tbl[1]  = '{12'hFFE, 12'h003, 1'b0, 1'b1, 1'b0, 2'b00, 32'h000000AB, 4'd0,  0, 1'b0, 32'h0,        12'h001, 1'b0, 1'b1, 2'b00, 2, 1'b0};
    tbl[2]  = '{12'hFFF, 12'h000, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0,        4'd2, -1, 1'b0, 32'h0,        12'h000, 1'b0, 1'b0, 2'b01, 1, 1'b0};
    tbl[3]  = '{12'h010, 12'h020, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0,        4'd6, -1, 1'b0, 32'h0,        12'h030, 1'b1, 1'b0, 2'b11, 10, 1'b0};
    tbl[4]  = '{12'h040, 12'h001, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0,        4'd7,  0, 1'b0, 32'h00000012, 12'h041, 1'b1, 1'b0, 2'b00, 2, 1'b1};
    tbl[5]  = '{12'h050, 12'h000, 1'b1, 1'b1, 1'b0, 2'b10, 32'h0,        4'd1, -1, 1'b0, 32'h0,        12'h000, 1'b0, 1'b0, 2'b10, 1, 1'b0};
    tbl[6]  = '{12'hFFF, 12'h000, 1'b1, 1'b1, 1'b0, 2'b10, 32'h0,        4'd1, -1, 1'b0, 32'h0,        12'h000, 1'b0, 1'b0, 2'b10, 1, 1'b0};
    tbl[7]  = '{12'hFF0, 12'h00F, 1'b0, 1'b1, 1'b0, 2'b01, 32'h12345678, 4'd0,  2, 1'b1, 32'h0,        12'hFFF, 1'b0, 1'b1, 2'b00, 4, 1'b0};
    tbl[8]  = '{12'h7FF, 12'h801, 1'b1, 1'b0, 1'b1, 2'b00, 32'h0,        4'd9,  3, 1'b1, 32'h00000080, 12'h000, 1'b1, 1'b0, 2'b00, 5, 1'b1};
    tbl[9]  = '{12'h123, 12'h456, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0,        4'd15, 7, 1'b0, 32'hCAFEF00D, 12'h579, 1'b1, 1'b0, 2'b00, 9, 1'b1};
    tbl[10] = '{12'hFFE, 12'h001, 1'b0, 1'b1, 1'b0, 2'b10, 32'h55AA55AA, 4'd0, -1, 1'b0, 32'h0,        12'h000, 1'b0, 1'b0, 2'b01, 1, 1'b0};

    reset = 1'b1;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_is_signed = 1'b0;
    ex_word_type = 2'b00; ex_base_addr = '0; ex_offset = '0;
    ex_store_data = '0; ex_dest_reg = '0;
    clear_resp();
    repeat (2) @(negedge clk);
    check("rst_outputs", {26'h0, stall, mi_bus.mi_load, mi_bus.mi_store, wb_valid, fault, 1'b0},
          32'h0);
    check("rst_fault_code", {30'h0, fault_code}, 32'h0);
    check("rst_addr", {20'h0, mi_bus.mi_address}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // ex_valid with neither load nor store must be ignored.
    ex_valid = 1'b1;
    ex_base_addr = 12'h222;
    repeat (2) @(negedge clk);
    check("noop_ignored", {30'h0, stall, mi_bus.mi_load}, 32'h0);
    ex_valid = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

    // Back-to-back: second request held during the first one's DONE cycle.
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_word_type = 2'b10;
    ex_base_addr = 12'h200; ex_offset = 12'h010; ex_dest_reg = 4'd3; ex_is_signed = 1'b0;
    sb.push_back('{r: 4'd3, d: 32'hA5A50001});
    @(negedge clk);
    check("b2b_a_issue", {19'h0, mi_bus.mi_load, mi_bus.mi_address}, {19'h0, 1'b1, 12'h210});
    ex_load = 1'b0; ex_store = 1'b1; ex_base_addr = 12'h300; ex_offset = 12'h001;
    ex_store_data = 32'h0BADF00D;
    @(negedge clk);
    mi_bus.mi_output_valid = 1'b1; mi_bus.mi_data_out = 32'hA5A50001;
    @(negedge clk);
    clear_resp();
    check("b2b_a_done", {30'h0, stall, wb_valid}, {30'h0, 1'b0, 1'b1});
    @(negedge clk);
    ex_valid = 1'b0;
    check("b2b_b_issue", {18'h0, stall, mi_bus.mi_store, mi_bus.mi_address},
          {18'h0, 1'b1, 1'b1, 12'h301});
    check("b2b_b_data", mi_bus.mi_data_in, 32'h0BADF00D);
    @(negedge clk);
    mi_bus.mi_write_ready = 1'b1;
    @(negedge clk);
    clear_resp();
    check("b2b_b_done", {30'h0, stall, wb_valid}, 32'h0);
    @(negedge clk);

    // Reset mid-WAIT abandons the load with no writeback.
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_word_type = 2'b10;
    ex_base_addr = 12'h0A0; ex_offset = 12'h001; ex_dest_reg = 4'd4;
    @(negedge clk);
    ex_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_stall", {31'h0, stall}, 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_drop", {29'h0, stall, mi_bus.mi_load, wb_valid}, 32'h0);
    check("mid_rst_code", {30'h0, fault_code}, 32'h0);
    last_code = 2'b00;
    mi_bus.mi_output_valid = 1'b1; mi_bus.mi_data_out = 32'h11111111;
    @(negedge clk);
    clear_resp();
    reset = 1'b0;
    run_vec(tbl[0], 100);

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
